instr_loader: RTL and testbench



---
 rtl/instr_loader_if.sv | 29 ++
 rtl/instr_loader.sv | 132 +++++++++++++
 tb/tb_instr_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream, memory write port and status bundle for instr_loader
interface instr_loader_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BYTE_WIDTH    = 8
);
    logic                     start_i;
    logic [BYTE_WIDTH-1:0]    byte_i;
    logic                     byte_valid_i;
    logic                     byte_ready_o;
    logic                     we_o;
    logic [ADDRESS_WIDTH-1:0] wa_o;
    logic [BYTE_WIDTH-1:0]    wd_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     err_o;
    logic                     hold_o;

    // host side: drives the stream and start, observes memory port and status
    modport master (
        output start_i, byte_i, byte_valid_i,
        input  byte_ready_o, we_o, wa_o, wd_o, busy_o, done_o, err_o, hold_o
    );

    // loader side
    modport slave (
        input  start_i, byte_i, byte_valid_i,
        output byte_ready_o, we_o, wa_o, wd_o, busy_o, done_o, err_o, hold_o
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot loader: length, payload, checksum stream into instruction memory
module instr_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int MEM_BYTES     = 4096
) (
    input  logic          clk_i,
    input  logic          rst_i,
    instr_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] MAX_LEN = ADDRESS_WIDTH'(MEM_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ONE     = ADDRESS_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] len_q, len_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BYTE_WIDTH-1:0]    sum_q, sum_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
    logic [BYTE_WIDTH-1:0]    wd_q, wd_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     hold_q, hold_d;

    logic                     accept;
    logic [ADDRESS_WIDTH-1:0] len_shift;

    // ready_q is a registered decode of the state, so accept never loops back into ready
    assign accept = bus.byte_valid_i && ready_q;
    // length arrives LSB first: shifting each byte in at the top leaves byte 0 in bits 7:0 after the 4th
    assign len_shift = {bus.byte_i, len_q[ADDRESS_WIDTH-1:BYTE_WIDTH]};

    // next-state, counter and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start_i) begin
                    state_d = LEN;
                    cnt_d   = '0;
                    len_d   = '0;
                    addr_d  = '0;
                    sum_d   = '0;
                end
            end
            LEN: begin
                if (accept) begin
                    len_d = len_shift;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (len_shift > MAX_LEN)      state_d = ERR;
                        else if (len_shift == '0)     state_d = CHK;
                        else                          state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    we_d   = 1'b1;
                    wa_d   = addr_q;
                    wd_d   = bus.byte_i;
                    addr_d = addr_q + ONE;
                    sum_d  = sum_q + bus.byte_i;
                    if (addr_q == len_q - ONE) state_d = CHK;
                end
            end
            CHK: begin
                if (accept) state_d = (bus.byte_i == sum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
        busy_d  = ready_d;
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
        hold_d  = (state_d != DONE);
    end

    // state and output registers; reset aborts any load and drops a pending write at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.we_o         = we_q;
    assign bus.wa_o         = wa_q;
    assign bus.wd_o         = wd_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
    assign bus.hold_o       = hold_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader
module tb_instr_loader;
    localparam int AW  = 32;
    localparam int BW  = 8;
    localparam int MEM = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_loader_if #(.ADDRESS_WIDTH(AW), .BYTE_WIDTH(BW)) bus ();
    instr_loader #(.ADDRESS_WIDTH(AW), .BYTE_WIDTH(BW), .MEM_BYTES(MEM)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:MEM-1];
    logic [31:0] got_a[$];
    logic [7:0]  got_d[$];

    // capture every memory write pulse
    always @(negedge clk) begin
        if (!rst && bus.we_o) begin
            got_a.push_back(bus.wa_o);
            got_d.push_back(bus.wd_o);
            if (bus.wa_o < MEM) mem[bus.wa_o[11:0]] = bus.wd_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    endfunction

    task automatic check_idle_reset(input string tag);
        chk({tag, ".ready"}, bus.byte_ready_o, 0);
        chk({tag, ".we"},    bus.we_o, 0);
        chk({tag, ".wa"},    bus.wa_o, 0);
        chk({tag, ".wd"},    bus.wd_o, 0);
        chk({tag, ".busy"},  bus.busy_o, 0);
        chk({tag, ".done"},  bus.done_o, 0);
        chk({tag, ".err"},   bus.err_o, 0);
        chk({tag, ".hold"},  bus.hold_o, 1);
    endtask

    // entered and left at posedge+1; returns once the byte has been accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            bus.byte_valid_i = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.byte_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("start.busy", bus.busy_o, 1);
        chk("start.hold", bus.hold_o, 1);
        chk("start.done", bus.done_o, 0);
        chk("start.err",  bus.err_o, 0);
        @(posedge clk);
        #1;
    endtask

    // full load of length n, payload pay, checksum ck; expectations derived from the stream rules
    task automatic do_load(input string tag, input logic [31:0] n, input logic [7:0] pay[$],
                           input logic [7:0] ck, input int gap);
        logic [7:0] s;
        bit         good;
        int         errs;
        got_a.delete();
        got_d.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], pick_gap(gap));
        if (n > MEM) begin
            bus.byte_valid_i = 1'b0;
            @(negedge clk);
            chk({tag, ".err"},   bus.err_o, 1);
            chk({tag, ".done"},  bus.done_o, 0);
            chk({tag, ".hold"},  bus.hold_o, 1);
            chk({tag, ".ready"}, bus.byte_ready_o, 0);
            chk({tag, ".busy"},  bus.busy_o, 0);
            repeat (3) @(negedge clk);
            chk({tag, ".nwr"},   got_a.size(), 0);
            @(posedge clk);
            #1;
            return;
        end
        s = 8'h00;
        foreach (pay[i]) begin
            send_byte(pay[i], pick_gap(gap));
            s = s + pay[i];
        end
        send_byte(ck, pick_gap(gap));
        bus.byte_valid_i = 1'b0;
        @(negedge clk);
        good = (ck == s);
        chk({tag, ".nwr"},   got_a.size(), n);
        chk({tag, ".done"},  bus.done_o, good);
        chk({tag, ".err"},   bus.err_o, !good);
        chk({tag, ".hold"},  bus.hold_o, !good);
        chk({tag, ".busy"},  bus.busy_o, 0);
        chk({tag, ".ready"}, bus.byte_ready_o, 0);
        errs = 0;
        for (int i = 0; i < got_a.size() && i < pay.size(); i++)
            if (got_a[i] !== 32'(i) || got_d[i] !== pay[i]) errs++;
        chk({tag, ".wr_errs"}, errs, 0);
        repeat (2) @(negedge clk);
        chk({tag, ".done_held"}, bus.done_o, good);
        chk({tag, ".err_held"},  bus.err_o, !good);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p[$];
        logic [7:0] q[$];
        logic [7:0] s;
        int         n;
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        #12;
        check_idle_reset("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        p = '{8'h13, 8'h00, 8'h50, 8'h00};
        do_load("basic", 32'd4, p, 8'h63, 0);
        chk("basic.word0", {mem[3], mem[2], mem[1], mem[0]}, 32'h00500013);

        for (int i = 0; i < 4; i++) mem[i] = 8'hxx;
        do_load("gaps", 32'd4, p, 8'h63, 3);
        chk("gaps.word0", {mem[3], mem[2], mem[1], mem[0]}, 32'h00500013);

        q.delete();
        do_load("zero", 32'd0, q, 8'h00, 0);
        do_load("oversize", 32'd4097, q, 8'h00, 1);
        do_load("from_err", 32'd4, p, 8'h63, 0);
        do_load("badsum", 32'd4, p, 8'hFF, 0);

        // reset in the middle of the payload
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h04 : 8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        bus.byte_valid_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_idle_reset("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_reset("midrst_after");
        @(posedge clk);
        #1;
        do_load("after_rst", 32'd4, p, 8'h63, 0);
        chk("after_rst.word0", {mem[3], mem[2], mem[1], mem[0]}, 32'h00500013);

        // random images, some with a corrupted checksum
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 24);
            q.delete();
            s = 8'h00;
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                s = s + q[i];
            end
            if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
            do_load($sformatf("rand%0d", t), 32'(n), q, s, -1);
        end

        // largest accepted image
        q.delete();
        s = 8'h00;
        for (int i = 0; i < MEM; i++) begin
            q.push_back(8'($urandom));
            s = s + q[i];
        end
        do_load("maxlen", 32'(MEM), q, s, 0);
        chk("maxlen.last", {24'h0, mem[MEM-1]}, {24'h0, q[MEM-1]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
